// File: rtl/blit_cmd_decoder_pkg.sv
// Shared definitions for the blit command decoder: opcodes, engine op codes,
// command field layout, FSM states and surface/clip reset defaults.
package blit_pkg;

   localparam int unsigned CMD_W        = 104;
   localparam int unsigned CMD_OPC_LSB  = 96;
   localparam int unsigned CMD_ARG0_LSB = 64;
   localparam int unsigned CMD_ARG1_LSB = 32;
   localparam int unsigned CMD_ARG2_LSB = 0;

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_SET_DST   = 8'h01;
   localparam logic [7:0] OP_SET_SRC   = 8'h02;
   localparam logic [7:0] OP_SET_CLIP  = 8'h03;
   localparam logic [7:0] OP_SET_COLOR = 8'h04;
   localparam logic [7:0] OP_FILL      = 8'h10;
   localparam logic [7:0] OP_COPY      = 8'h11;
   localparam logic [7:0] OP_LINE      = 8'h12;

   typedef enum logic [1:0] {
      ENG_FILL = 2'd0,
      ENG_COPY = 2'd1,
      ENG_LINE = 2'd2
   } eng_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_ISSUE  = 2'd2
   } state_e;

   localparam logic [15:0] DEF_STRIDE  = 16'd640;
   localparam logic [15:0] DEF_CLIP_X1 = 16'd0;
   localparam logic [15:0] DEF_CLIP_Y1 = 16'd0;
   localparam logic [15:0] DEF_CLIP_X2 = 16'd639;
   localparam logic [15:0] DEF_CLIP_Y2 = 16'd479;

endpackage

// File: rtl/blit_cmd_decoder_if.sv
// Command FIFO head and blit-engine request bundle between decoder and its peers.
interface blit_cmd_decoder_if;
   import blit_pkg::*;

   logic [CMD_W-1:0] cmd_cmd;
   logic             cmd_valid;
   logic             cmd_next;
   logic             eng_valid;
   logic             eng_ready;
   logic [1:0]       eng_op;
   logic [15:0]      eng_x1;
   logic [15:0]      eng_y1;
   logic [15:0]      eng_x2;
   logic [15:0]      eng_y2;
   logic [15:0]      eng_sx;
   logic [15:0]      eng_sy;
   logic [31:0]      eng_dst_base;
   logic [31:0]      eng_src_base;
   logic [15:0]      eng_dst_stride;
   logic [15:0]      eng_src_stride;
   logic [7:0]       eng_fg;
   logic [7:0]       eng_bg;

   modport master (
      input  cmd_cmd, cmd_valid, eng_ready,
      output cmd_next, eng_valid, eng_op, eng_x1, eng_y1, eng_x2, eng_y2,
             eng_sx, eng_sy, eng_dst_base, eng_src_base, eng_dst_stride,
             eng_src_stride, eng_fg, eng_bg
   );

   modport slave (
      output cmd_cmd, cmd_valid, eng_ready,
      input  cmd_next, eng_valid, eng_op, eng_x1, eng_y1, eng_x2, eng_y2,
             eng_sx, eng_sy, eng_dst_base, eng_src_base, eng_dst_stride,
             eng_src_stride, eng_fg, eng_bg
   );

endinterface

// File: rtl/blit_cmd_decoder_clip.sv
// Combinational rectangle clip against the clip window, with the COPY source
// origin shifted by however far the top-left corner moved.
module blit_clip (
   input  logic [15:0] x1,
   input  logic [15:0] y1,
   input  logic [15:0] x2,
   input  logic [15:0] y2,
   input  logic [15:0] clip_x1,
   input  logic [15:0] clip_y1,
   input  logic [15:0] clip_x2,
   input  logic [15:0] clip_y2,
   input  logic [15:0] sx,
   input  logic [15:0] sy,
   output logic [15:0] cx1,
   output logic [15:0] cy1,
   output logic [15:0] cx2,
   output logic [15:0] cy2,
   output logic [15:0] csx,
   output logic [15:0] csy,
   output logic        empty
);

   always_comb begin
      cx1   = (x1 > clip_x1) ? x1 : clip_x1;
      cy1   = (y1 > clip_y1) ? y1 : clip_y1;
      cx2   = (x2 < clip_x2) ? x2 : clip_x2;
      cy2   = (y2 < clip_y2) ? y2 : clip_y2;
      empty = (cx1 > cx2) || (cy1 > cy2);
      csx   = sx + (cx1 - x1);
      csy   = sy + (cy1 - y1);
   end

endmodule

// File: rtl/blit_cmd_decoder.sv
// Pops blit commands from a FIFO, tracks surface/clip/colour state and issues
// clipped draw requests to the blit engine with a valid/ready handshake.
module blit_cmd_decoder
   import blit_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   blit_cmd_decoder_if.master  bus,
   input  logic                err_clear,
   output logic                busy,
   output logic                err_opcode,
   output logic [15:0]         cmd_count
);

   state_e           state_q, state_d;
   logic [CMD_W-1:0] cmd_reg_q, cmd_reg_d;
   logic [31:0]      dst_base_q, dst_base_d, src_base_q, src_base_d;
   logic [15:0]      dst_stride_q, dst_stride_d, src_stride_q, src_stride_d;
   logic [15:0]      clip_x1_q, clip_x1_d, clip_y1_q, clip_y1_d;
   logic [15:0]      clip_x2_q, clip_x2_d, clip_y2_q, clip_y2_d;
   logic [7:0]       fg_q, fg_d, bg_q, bg_d;
   logic             err_opcode_q, err_opcode_d;
   logic [15:0]      cmd_count_q, cmd_count_d;

   logic             eng_valid_q, eng_valid_d;
   eng_op_e          eng_op_q, eng_op_d;
   logic [15:0]      eng_x1_q, eng_x1_d, eng_y1_q, eng_y1_d;
   logic [15:0]      eng_x2_q, eng_x2_d, eng_y2_q, eng_y2_d;
   logic [15:0]      eng_sx_q, eng_sx_d, eng_sy_q, eng_sy_d;
   logic [31:0]      eng_dst_base_q, eng_dst_base_d, eng_src_base_q, eng_src_base_d;
   logic [15:0]      eng_dst_stride_q, eng_dst_stride_d, eng_src_stride_q, eng_src_stride_d;
   logic [7:0]       eng_fg_q, eng_fg_d, eng_bg_q, eng_bg_d;

   logic             cmd_next;
   logic             count_inc;
   logic             err_set;
   logic             launch;
   logic [7:0]       opc;
   logic [31:0]      a0, a1, a2;
   logic [15:0]      fill_x1, fill_y1, fill_x2, fill_y2;
   logic [15:0]      copy_x2, copy_y2;
   logic [15:0]      rect_x1, rect_y1, rect_x2, rect_y2;
   logic [15:0]      cx1, cy1, cx2, cy2, csx, csy;
   logic             clip_empty;

   assign opc = cmd_reg_q[CMD_OPC_LSB  +: 8];
   assign a0  = cmd_reg_q[CMD_ARG0_LSB +: 32];
   assign a1  = cmd_reg_q[CMD_ARG1_LSB +: 32];
   assign a2  = cmd_reg_q[CMD_ARG2_LSB +: 32];

   // FILL corners are normalised before clipping; COPY extent wraps at 16 bits.
   always_comb begin
      fill_x1 = (a0[31:16] <= a1[31:16]) ? a0[31:16] : a1[31:16];
      fill_x2 = (a0[31:16] <= a1[31:16]) ? a1[31:16] : a0[31:16];
      fill_y1 = (a0[15:0]  <= a1[15:0])  ? a0[15:0]  : a1[15:0];
      fill_y2 = (a0[15:0]  <= a1[15:0])  ? a1[15:0]  : a0[15:0];
      copy_x2 = a0[31:16] + a1[31:16] - 16'd1;
      copy_y2 = a0[15:0]  + a1[15:0]  - 16'd1;
      if (opc == OP_COPY) begin
         rect_x1 = a0[31:16];
         rect_y1 = a0[15:0];
         rect_x2 = copy_x2;
         rect_y2 = copy_y2;
      end else begin
         rect_x1 = fill_x1;
         rect_y1 = fill_y1;
         rect_x2 = fill_x2;
         rect_y2 = fill_y2;
      end
   end

   blit_clip u_clip (
      .x1(rect_x1), .y1(rect_y1), .x2(rect_x2), .y2(rect_y2),
      .clip_x1(clip_x1_q), .clip_y1(clip_y1_q),
      .clip_x2(clip_x2_q), .clip_y2(clip_y2_q),
      .sx(a2[31:16]), .sy(a2[15:0]),
      .cx1(cx1), .cy1(cy1), .cx2(cx2), .cy2(cy2),
      .csx(csx), .csy(csy), .empty(clip_empty)
   );

   always_comb begin
      state_d          = state_q;
      cmd_reg_d        = cmd_reg_q;
      dst_base_d       = dst_base_q;
      dst_stride_d     = dst_stride_q;
      src_base_d       = src_base_q;
      src_stride_d     = src_stride_q;
      clip_x1_d        = clip_x1_q;
      clip_y1_d        = clip_y1_q;
      clip_x2_d        = clip_x2_q;
      clip_y2_d        = clip_y2_q;
      fg_d             = fg_q;
      bg_d             = bg_q;
      eng_valid_d      = eng_valid_q;
      eng_op_d         = eng_op_q;
      eng_x1_d         = eng_x1_q;
      eng_y1_d         = eng_y1_q;
      eng_x2_d         = eng_x2_q;
      eng_y2_d         = eng_y2_q;
      eng_sx_d         = eng_sx_q;
      eng_sy_d         = eng_sy_q;
      eng_dst_base_d   = eng_dst_base_q;
      eng_src_base_d   = eng_src_base_q;
      eng_dst_stride_d = eng_dst_stride_q;
      eng_src_stride_d = eng_src_stride_q;
      eng_fg_d         = eng_fg_q;
      eng_bg_d         = eng_bg_q;
      cmd_next         = 1'b0;
      count_inc        = 1'b0;
      err_set          = 1'b0;
      launch           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && !reset) begin
               cmd_next  = 1'b1;
               cmd_reg_d = bus.cmd_cmd;
               state_d   = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_IDLE;
            case (opc)
               OP_NOP: count_inc = 1'b1;
               OP_SET_DST: begin
                  dst_base_d   = a0;
                  dst_stride_d = a1[15:0];
                  count_inc    = 1'b1;
               end
               OP_SET_SRC: begin
                  src_base_d   = a0;
                  src_stride_d = a1[15:0];
                  count_inc    = 1'b1;
               end
               OP_SET_CLIP: begin
                  clip_x1_d = a0[31:16];
                  clip_y1_d = a0[15:0];
                  clip_x2_d = a1[31:16];
                  clip_y2_d = a1[15:0];
                  count_inc = 1'b1;
               end
               OP_SET_COLOR: begin
                  fg_d      = a0[7:0];
                  bg_d      = a1[7:0];
                  count_inc = 1'b1;
               end
               OP_FILL: begin
                  if (clip_empty) count_inc = 1'b1;
                  else begin
                     launch   = 1'b1;
                     eng_op_d = ENG_FILL;
                     eng_x1_d = cx1;
                     eng_y1_d = cy1;
                     eng_x2_d = cx2;
                     eng_y2_d = cy2;
                     eng_sx_d = '0;
                     eng_sy_d = '0;
                  end
               end
               OP_COPY: begin
                  if (clip_empty || a1[31:16] == '0 || a1[15:0] == '0) count_inc = 1'b1;
                  else begin
                     launch   = 1'b1;
                     eng_op_d = ENG_COPY;
                     eng_x1_d = cx1;
                     eng_y1_d = cy1;
                     eng_x2_d = cx2;
                     eng_y2_d = cy2;
                     eng_sx_d = csx;
                     eng_sy_d = csy;
                  end
               end
               OP_LINE: begin
                  launch   = 1'b1;
                  eng_op_d = ENG_LINE;
                  eng_x1_d = a0[31:16];
                  eng_y1_d = a0[15:0];
                  eng_x2_d = a1[31:16];
                  eng_y2_d = a1[15:0];
                  eng_sx_d = '0;
                  eng_sy_d = '0;
               end
               default: begin
                  err_set   = 1'b1;
                  count_inc = 1'b1;
               end
            endcase
         end
         ST_ISSUE: begin
            if (bus.eng_ready) begin
               eng_valid_d = 1'b0;
               count_inc   = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Surface and colour are snapshotted into the request so later SET_* can't leak in.
      if (launch) begin
         eng_valid_d      = 1'b1;
         eng_dst_base_d   = dst_base_q;
         eng_dst_stride_d = dst_stride_q;
         eng_src_base_d   = src_base_q;
         eng_src_stride_d = src_stride_q;
         eng_fg_d         = fg_q;
         eng_bg_d         = bg_q;
         state_d          = ST_ISSUE;
      end

      cmd_count_d  = count_inc ? cmd_count_q + 16'd1 : cmd_count_q;
      err_opcode_d = err_clear ? 1'b0 : err_opcode_q;
      if (err_set) err_opcode_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         cmd_reg_q        <= '0;
         dst_base_q       <= '0;
         dst_stride_q     <= DEF_STRIDE;
         src_base_q       <= '0;
         src_stride_q     <= DEF_STRIDE;
         clip_x1_q        <= DEF_CLIP_X1;
         clip_y1_q        <= DEF_CLIP_Y1;
         clip_x2_q        <= DEF_CLIP_X2;
         clip_y2_q        <= DEF_CLIP_Y2;
         fg_q             <= 8'hFF;
         bg_q             <= 8'h00;
         err_opcode_q     <= 1'b0;
         cmd_count_q      <= '0;
         eng_valid_q      <= 1'b0;
         eng_op_q         <= ENG_FILL;
         eng_x1_q         <= '0;
         eng_y1_q         <= '0;
         eng_x2_q         <= '0;
         eng_y2_q         <= '0;
         eng_sx_q         <= '0;
         eng_sy_q         <= '0;
         eng_dst_base_q   <= '0;
         eng_src_base_q   <= '0;
         eng_dst_stride_q <= '0;
         eng_src_stride_q <= '0;
         eng_fg_q         <= '0;
         eng_bg_q         <= '0;
      end else begin
         state_q          <= state_d;
         cmd_reg_q        <= cmd_reg_d;
         dst_base_q       <= dst_base_d;
         dst_stride_q     <= dst_stride_d;
         src_base_q       <= src_base_d;
         src_stride_q     <= src_stride_d;
         clip_x1_q        <= clip_x1_d;
         clip_y1_q        <= clip_y1_d;
         clip_x2_q        <= clip_x2_d;
         clip_y2_q        <= clip_y2_d;
         fg_q             <= fg_d;
         bg_q             <= bg_d;
         err_opcode_q     <= err_opcode_d;
         cmd_count_q      <= cmd_count_d;
         eng_valid_q      <= eng_valid_d;
         eng_op_q         <= eng_op_d;
         eng_x1_q         <= eng_x1_d;
         eng_y1_q         <= eng_y1_d;
         eng_x2_q         <= eng_x2_d;
         eng_y2_q         <= eng_y2_d;
         eng_sx_q         <= eng_sx_d;
         eng_sy_q         <= eng_sy_d;
         eng_dst_base_q   <= eng_dst_base_d;
         eng_src_base_q   <= eng_src_base_d;
         eng_dst_stride_q <= eng_dst_stride_d;
         eng_src_stride_q <= eng_src_stride_d;
         eng_fg_q         <= eng_fg_d;
         eng_bg_q         <= eng_bg_d;
      end
   end

   assign bus.cmd_next       = cmd_next;
   assign bus.eng_valid      = eng_valid_q;
   assign bus.eng_op         = eng_op_q;
   assign bus.eng_x1         = eng_x1_q;
   assign bus.eng_y1         = eng_y1_q;
   assign bus.eng_x2         = eng_x2_q;
   assign bus.eng_y2         = eng_y2_q;
   assign bus.eng_sx         = eng_sx_q;
   assign bus.eng_sy         = eng_sy_q;
   assign bus.eng_dst_base   = eng_dst_base_q;
   assign bus.eng_src_base   = eng_src_base_q;
   assign bus.eng_dst_stride = eng_dst_stride_q;
   assign bus.eng_src_stride = eng_src_stride_q;
   assign bus.eng_fg         = eng_fg_q;
   assign bus.eng_bg         = eng_bg_q;
   assign busy               = (state_q != ST_IDLE);
   assign err_opcode         = err_opcode_q;
   assign cmd_count          = cmd_count_q;

endmodule

// File: tb/tb_blit_cmd_decoder.sv
// Scoreboard bench for blit_cmd_decoder: a FIFO model feeds directed commands,
// expected engine requests are queued and checked by an independent monitor.
module tb_blit_cmd_decoder;
   import blit_pkg::*;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] x1, y1, x2, y2, sx, sy;
      logic [31:0] db, sb;
      logic [15:0] ds, ss;
      logic [7:0]  fg, bg;
   } eng_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        err_clear;
   logic        busy;
   logic        err_opcode;
   logic [15:0] cmd_count;

   blit_cmd_decoder_if bus ();

   blit_cmd_decoder dut (
      .clock(clock), .reset(reset), .bus(bus), .err_clear(err_clear),
      .busy(busy), .err_opcode(err_opcode), .cmd_count(cmd_count)
   );

   always #5 clock = ~clock;

   logic [CMD_W-1:0] fifo_q[$];
   eng_t             exp_q[$];
   int               checks = 0;
   int               failures = 0;
   int               exp_count = 0;
   int               valid_cycles = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] xy(input logic [15:0] x, input logic [15:0] y);
      return {x, y};
   endfunction

   function automatic logic [CMD_W-1:0] mkc(input logic [7:0] op, input logic [31:0] a0,
                                            input logic [31:0] a1, input logic [31:0] a2);
      return {op, a0, a1, a2};
   endfunction

   function automatic eng_t mk_eng(input logic [1:0] op, input logic [15:0] x1, y1, x2, y2, sx, sy,
                                   input logic [31:0] db, input logic [15:0] ds,
                                   input logic [31:0] sb, input logic [15:0] ss,
                                   input logic [7:0] fg, input logic [7:0] bg);
      eng_t e;
      e.op = op; e.x1 = x1; e.y1 = y1; e.x2 = x2; e.y2 = y2; e.sx = sx; e.sy = sy;
      e.db = db; e.ds = ds; e.sb = sb; e.ss = ss; e.fg = fg; e.bg = bg;
      return e;
   endfunction

   task automatic push_cmd(input logic [CMD_W-1:0] c);
      fifo_q.push_back(c);
      exp_count++;
   endtask

   task automatic push_draw(input logic [CMD_W-1:0] c, input eng_t e);
      exp_q.push_back(e);
      push_cmd(c);
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((fifo_q.size() != 0 || busy || bus.cmd_valid) && n < limit) begin
         @(negedge clock);
         n++;
      end
      if (n >= limit) check("drain_timeout", 1, 0);
      @(negedge clock);
   endtask

   // FIFO model: pop is decided from cmd_next mid-cycle, head updates after the edge,
   // and the cycle after a pop shows a refill bubble.
   initial begin
      logic pop;
      logic bubble;
      bus.cmd_valid = 1'b0;
      bus.cmd_cmd   = '0;
      forever begin
         @(negedge clock);
         pop = bus.cmd_next;
         if (reset && bus.cmd_valid) check("cmd_next_in_reset", bus.cmd_next, 0);
         @(posedge clock);
         #1;
         bubble = 1'b0;
         if (pop === 1'b1 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            bubble = 1'b1;
         end
         if (fifo_q.size() > 0 && !bubble) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_cmd   = fifo_q[0];
         end else begin
            bus.cmd_valid = 1'b0;
         end
      end
   end

   // Monitor: scoreboard compare on accept, hold check while stalled.
   initial begin
      logic [209:0] cur_f, prev_f;
      logic         prev_valid, prev_ready, prev_rst;
      eng_t         e;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_rst   = 1'b1;
      prev_f     = '0;
      forever begin
         @(negedge clock);
         cur_f = {bus.eng_op, bus.eng_x1, bus.eng_y1, bus.eng_x2, bus.eng_y2, bus.eng_sx,
                  bus.eng_sy, bus.eng_dst_base, bus.eng_src_base, bus.eng_dst_stride,
                  bus.eng_src_stride, bus.eng_fg, bus.eng_bg};
         if (!reset && !prev_rst && prev_valid === 1'b1 && prev_ready === 1'b0)
            check("eng_hold", {bus.eng_valid, cur_f}, {1'b1, prev_f});
         if (!reset && bus.eng_valid === 1'b1) begin
            valid_cycles++;
            if (bus.eng_ready) begin
               if (exp_q.size() == 0) check("unexpected_req", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("eng_op", bus.eng_op, e.op);
                  check("eng_x1", bus.eng_x1, e.x1);
                  check("eng_y1", bus.eng_y1, e.y1);
                  check("eng_x2", bus.eng_x2, e.x2);
                  check("eng_y2", bus.eng_y2, e.y2);
                  if (e.op == 2'd1) begin
                     check("eng_sx", bus.eng_sx, e.sx);
                     check("eng_sy", bus.eng_sy, e.sy);
                  end
                  check("eng_dst_base", bus.eng_dst_base, e.db);
                  check("eng_dst_stride", bus.eng_dst_stride, e.ds);
                  check("eng_src_base", bus.eng_src_base, e.sb);
                  check("eng_src_stride", bus.eng_src_stride, e.ss);
                  check("eng_fg", bus.eng_fg, e.fg);
                  check("eng_bg", bus.eng_bg, e.bg);
               end
            end
         end
         prev_f     = cur_f;
         prev_valid = bus.eng_valid;
         prev_ready = bus.eng_ready;
         prev_rst   = reset;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c0;
      int v0;
      int pulses[$];
      reset         = 1'b1;
      err_clear     = 1'b0;
      bus.eng_ready = 1'b1;

      // Reset state, with a command waiting that must not be popped.
      repeat (2) @(negedge clock);
      push_cmd(mkc(OP_NOP, 0, 0, 0));
      repeat (3) @(negedge clock);
      check("rst_eng_valid", bus.eng_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_opcode, 0);
      check("rst_count", cmd_count, 0);
      @(posedge clock); #1 reset = 1'b0;
      drain(50);
      check("count_after_nop", cmd_count, exp_count);

      // Clip then FILL.
      push_cmd(mkc(OP_SET_CLIP, xy(10, 20), xy(100, 200), 0));
      push_draw(mkc(OP_FILL, xy(0, 0), xy(50, 300), 0),
                mk_eng(2'd0, 10, 20, 50, 200, 0, 0, 0, 640, 0, 640, 8'hFF, 8'h00));
      // Default clip, reversed corners.
      push_cmd(mkc(OP_SET_CLIP, xy(0, 0), xy(639, 479), 0));
      push_draw(mkc(OP_FILL, xy(5, 5), xy(3, 3), 0),
                mk_eng(2'd0, 3, 3, 5, 5, 0, 0, 0, 640, 0, 640, 8'hFF, 8'h00));
      // COPY with top-left clipped, source shifted.
      push_cmd(mkc(OP_SET_CLIP, xy(10, 10), xy(639, 479), 0));
      push_draw(mkc(OP_COPY, xy(0, 0), xy(32, 32), xy(50, 60)),
                mk_eng(2'd1, 10, 10, 31, 31, 60, 70, 0, 640, 0, 640, 8'hFF, 8'h00));
      // LINE ignores clip and ordering.
      push_draw(mkc(OP_LINE, xy(700, 5), xy(2, 900), 0),
                mk_eng(2'd2, 700, 5, 2, 900, 0, 0, 0, 640, 0, 640, 8'hFF, 8'h00));
      drain(200);
      check("count_phase1", cmd_count, exp_count);

      // Colour/source snapshot, zero-size COPY and 16-bit wrap COPY are skipped.
      push_cmd(mkc(OP_SET_COLOR, 32'hAAAA_AA12, 32'h5555_5534, 0));
      push_cmd(mkc(OP_SET_SRC, 32'hABCD_0000, 32'hFFFF_0200, 0));
      push_cmd(mkc(OP_COPY, xy(20, 20), xy(0, 5), xy(0, 0)));
      push_cmd(mkc(OP_COPY, xy(16'hFFF0, 20), xy(16'h0020, 4), xy(0, 0)));
      push_draw(mkc(OP_COPY, xy(20, 30), xy(5, 4), xy(1, 2)),
                mk_eng(2'd1, 20, 30, 24, 33, 1, 2, 0, 640, 32'hABCD_0000, 16'h0200, 8'h12, 8'h34));
      drain(200);
      check("count_phase2", cmd_count, exp_count);

      // Long stall in ISSUE with SET_DST queued behind it.
      bus.eng_ready = 1'b0;
      push_draw(mkc(OP_FILL, xy(20, 20), xy(30, 30), 0),
                mk_eng(2'd0, 20, 20, 30, 30, 0, 0, 0, 640, 32'hABCD_0000, 16'h0200, 8'h12, 8'h34));
      push_cmd(mkc(OP_SET_DST, 32'h0000_1000, 32'h0000_0100, 0));
      push_draw(mkc(OP_FILL, xy(41, 40), xy(40, 41), 0),
                mk_eng(2'd0, 40, 40, 41, 41, 0, 0, 32'h1000, 16'h0100, 32'hABCD_0000, 16'h0200, 8'h12, 8'h34));
      n = 0;
      while (bus.eng_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      check("stall_issue", bus.eng_valid, 1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         check("stall_cmd_next", bus.cmd_next, 0);
      end
      @(posedge clock); #1 bus.eng_ready = 1'b1;
      drain(200);
      check("count_phase3", cmd_count, exp_count);

      // Unknown opcode: set wins over a simultaneous clear.
      c0 = exp_count;
      check("err_before", err_opcode, 0);
      push_cmd(mkc(8'h7F, 0, 0, 0));
      n = 0;
      while (bus.cmd_next !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      check("bad_op_popped", bus.cmd_next, 1);
      @(posedge clock); #1 err_clear = 1'b1;
      @(posedge clock); #1 err_clear = 1'b0;
      @(negedge clock);
      check("err_set_wins", err_opcode, 1);
      @(posedge clock); #1 err_clear = 1'b1;
      @(posedge clock); #1 err_clear = 1'b0;
      @(negedge clock);
      check("err_cleared", err_opcode, 0);
      v0 = valid_cycles;
      push_cmd(mkc(OP_FILL, xy(700, 0), xy(800, 5), 0));
      drain(100);
      check("outside_no_req", valid_cycles, v0);
      check("count_plus2", cmd_count, c0 + 2);

      // Reset mid-ISSUE discards the request; NOPs then retire every 2nd cycle.
      bus.eng_ready = 1'b0;
      push_cmd(mkc(OP_FILL, xy(20, 20), xy(30, 30), 0));
      n = 0;
      while (bus.eng_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      check("rst_issue_valid", bus.eng_valid, 1);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      exp_count = 0;
      bus.eng_ready = 1'b1;
      @(negedge clock);
      check("post_rst_valid", bus.eng_valid, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_count", cmd_count, 0);
      repeat (4) push_cmd(mkc(OP_NOP, 0, 0, 0));
      for (int i = 0; i < 24; i++) begin
         @(negedge clock);
         if (bus.cmd_next === 1'b1) pulses.push_back(i);
      end
      check("nop_pulses", pulses.size(), 4);
      for (int i = 1; i < pulses.size(); i++)
         check("nop_spacing", pulses[i] - pulses[i-1], 2);
      drain(50);
      check("nop_count", cmd_count, 4);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
